// File: rtl/axi_rd_arb.sv
// axi_rd_arb: shares one AXI AR/R read port between the inst and data caches.
// One transaction in flight at a time; ARID 0 = inst, 1 = data; R beats are
// routed to the latched owner. Data reads wait for an idle write buffer.
// Optional macro RD_ARB_RR_EN: round-robin arbitration on conflicts
// (undefined: data always wins).
module axi_rd_arb #(
    parameter int BYTES_PER_LINE = 16,
    parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction cache
    input  logic        i_rd_req,
    output logic        i_rd_rdy,
    input  logic        i_rd_burst,
    input  logic [31:0] i_rd_addr,
    output logic        i_ret_valid,
    output logic        i_ret_last,
    output logic [31:0] i_ret_data,
    // data cache
    input  logic        d_rd_req,
    output logic        d_rd_rdy,
    input  logic        d_rd_burst,
    input  logic [31:0] d_rd_addr,
    input  logic [1:0]  d_rd_size,
    output logic        d_ret_valid,
    output logic        d_ret_last,
    output logic [31:0] d_ret_data,
    // write buffer interlock
    input  logic        wr_idle,
    output logic        read_unfinish,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } state_t;

    state_t      state;
    logic        owner_d;   // 1 = data cache owns the current transaction
    logic [31:0] addr_q;
    logic        burst_q;
    logic [1:0]  size_q;
    logic        prefer_d;
    logic        grant_i;
    logic        grant_d;
    logic        i_elig;
    logic        d_elig;

`ifdef RD_ARB_RR_EN
    logic        last_d;    // last accepted grant went to data
`endif

    // routing follows owner only; response id and status are not consulted
    logic        unused_r;
    assign unused_r = ^{rid, rresp};

    // grant selection among eligible requesters
    always_comb begin
        i_elig = i_rd_req;
        d_elig = d_rd_req & wr_idle;
`ifdef RD_ARB_RR_EN
        prefer_d = ~last_d;
`else
        prefer_d = 1'b1;
`endif
        grant_d = d_elig & (~i_elig | prefer_d);
        grant_i = i_elig & ~grant_d;
    end

    // transaction sequencer: latch request, issue AR, drain R beats
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner_d <= 1'b0;
            addr_q  <= '0;
            burst_q <= 1'b0;
            size_q  <= '0;
`ifdef RD_ARB_RR_EN
            last_d  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_i | grant_d) begin
                        state   <= ST_AR;
                        owner_d <= grant_d;
                        addr_q  <= grant_d ? d_rd_addr : i_rd_addr;
                        burst_q <= grant_d ? d_rd_burst : i_rd_burst;
                        size_q  <= grant_d ? d_rd_size : 2'd2;
`ifdef RD_ARB_RR_EN
                        last_d  <= grant_d;
`endif
                    end
                end
                ST_AR: begin
                    if (arready) state <= ST_R;
                end
                ST_R: begin
                    if (rvalid & rlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // handshake, AR encoding and R routing derived from registered state
    always_comb begin
        i_rd_rdy      = (state == ST_IDLE) & grant_i;
        d_rd_rdy      = (state == ST_IDLE) & grant_d;
        read_unfinish = (state != ST_IDLE);

        arvalid = (state == ST_AR);
        arid    = {3'b000, owner_d};
        araddr  = addr_q;
        arlen   = burst_q ? 8'(WORDS_PER_LINE - 1) : '0;
        arsize  = burst_q ? 3'd2 : {1'b0, size_q};
        arburst = burst_q ? 2'b01 : 2'b00;
        arlock  = '0;
        arcache = '0;
        arprot  = '0;

        rready      = (state == ST_R);
        i_ret_valid = (state == ST_R) & rvalid & ~owner_d;
        d_ret_valid = (state == ST_R) & rvalid & owner_d;
        i_ret_last  = rlast;
        d_ret_last  = rlast;
        i_ret_data  = rdata;
        d_ret_data  = rdata;
    end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: expected AR requests and R beats are queued
// as stimulus is driven and checked as the DUT presents them.
// Honours RD_ARB_RR_EN for the arbitration-order expectations.
module tb_axi_rd_arb;

    logic        clk;
    logic        reset;
    logic        i_rd_req, i_rd_rdy, i_rd_burst;
    logic [31:0] i_rd_addr;
    logic        i_ret_valid, i_ret_last;
    logic [31:0] i_ret_data;
    logic        d_rd_req, d_rd_rdy, d_rd_burst;
    logic [31:0] d_rd_addr;
    logic [1:0]  d_rd_size;
    logic        d_ret_valid, d_ret_last;
    logic [31:0] d_ret_data;
    logic        wr_idle, read_unfinish;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef struct {
        bit          is_d;
        bit          last;
        logic [31:0] data;
    } beat_t;

    ar_t   ar_q[$];
    beat_t beat_q[$];
    int    passed = 0;
    int    total  = 0;

    axi_rd_arb #(.BYTES_PER_LINE(16)) dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_rdy(i_rd_rdy), .i_rd_burst(i_rd_burst),
        .i_rd_addr(i_rd_addr), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_rdy(d_rd_rdy), .d_rd_burst(d_rd_burst),
        .d_rd_addr(d_rd_addr), .d_rd_size(d_rd_size), .d_ret_valid(d_ret_valid),
        .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .wr_idle(wr_idle), .read_unfinish(read_unfinish),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ar(input bit is_d, input bit burst, input logic [31:0] addr,
                           input logic [1:0] size);
        ar_t e;
        e.id    = is_d ? 4'd1 : 4'd0;
        e.addr  = addr;
        e.len   = burst ? 8'd3 : 8'd0;
        e.size  = burst ? 3'd2 : (is_d ? {1'b0, size} : 3'd2);
        e.burst = burst ? 2'b01 : 2'b00;
        ar_q.push_back(e);
    endtask

    // present one request in IDLE, expect immediate acceptance
    task automatic request(input bit is_d, input bit burst, input logic [31:0] addr,
                           input logic [1:0] size);
        if (is_d) begin
            d_rd_req = 1'b1; d_rd_burst = burst; d_rd_addr = addr; d_rd_size = size;
        end else begin
            i_rd_req = 1'b1; i_rd_burst = burst; i_rd_addr = addr;
        end
        #1;
        check(is_d ? "d_rd_rdy" : "i_rd_rdy", is_d ? d_rd_rdy : i_rd_rdy, 1);
        check("unfinish_grant", read_unfinish, 0);
        push_ar(is_d, burst, addr, size);
        tick();
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
    endtask

    // expect arvalid now; hold arready low for 'delay' cycles then accept
    task automatic ar_phase(input int delay);
        ar_t e;
        check("arvalid", arvalid, 1);
        check("unfinish_ar", read_unfinish, 1);
        if (arvalid && ar_q.size() > 0) begin
            e = ar_q.pop_front();
            for (int k = 0; k <= delay; k++) begin
                check("arvalid_hold", arvalid, 1);
                check("arid", arid, e.id);
                check("araddr", araddr, e.addr);
                check("arlen", arlen, e.len);
                check("arsize", arsize, e.size);
                check("arburst", arburst, e.burst);
                check("ar_misc", {arlock, arcache, arprot}, 0);
                check("rready_ar", rready, 0);
                if (k < delay) tick();
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // drive one R beat and check routing in the same cycle
    task automatic beat(input bit is_d, input bit last);
        beat_t e;
        e.is_d = is_d;
        e.last = last;
        e.data = $urandom;
        beat_q.push_back(e);
        rvalid = 1'b1;
        rdata  = e.data;
        rlast  = last;
        rid    = is_d ? 4'd0 : 4'd1;  // deliberately wrong id: must be ignored
        #1;
        check("rready", rready, 1);
        check("unfinish_r", read_unfinish, 1);
        if ((i_ret_valid | d_ret_valid) && beat_q.size() > 0) begin
            e = beat_q.pop_front();
            check("i_ret_valid", i_ret_valid, !e.is_d);
            check("d_ret_valid", d_ret_valid, e.is_d);
            check("ret_last", e.is_d ? d_ret_last : i_ret_last, e.last);
            check("ret_data", e.is_d ? d_ret_data : i_ret_data, e.data);
        end else begin
            check("ret_valid_any", i_ret_valid | d_ret_valid, 1);
        end
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_unfinish"}, read_unfinish, 0);
        check({tag, "_ret_valid"}, {i_ret_valid, d_ret_valid}, 0);
    endtask

    initial begin
        bit exp_d;
        reset = 1'b1;
        i_rd_req = 0; i_rd_burst = 0; i_rd_addr = '0;
        d_rd_req = 0; d_rd_burst = 0; d_rd_addr = '0; d_rd_size = '0;
        wr_idle = 1'b1; arready = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_rdy", {i_rd_rdy, d_rd_rdy}, 0);
        reset = 1'b0;
        tick();

        // rvalid outside a transaction is not acknowledged
        rvalid = 1'b1;
        #1;
        check_quiet("stray_r");
        rvalid = 1'b0;
        tick();

        // single data read
        request(1, 0, 32'h1fc0_0004, 2'd2);
        ar_phase(0);
        beat(1, 1);
        check_quiet("after_single");

        // byte-size data read
        request(1, 0, 32'h0000_0043, 2'd0);
        ar_phase(1);
        beat(1, 1);

        // inst burst with delayed arready
        request(0, 1, 32'h0000_1000, 2'd0);
        ar_phase(3);
        for (int b = 0; b < 4; b++) beat(0, b == 3);
        check_quiet("after_burst");

        // data request blocked while write buffer busy
        wr_idle = 1'b0;
        d_rd_req = 1'b1; d_rd_burst = 1'b0; d_rd_addr = 32'h0000_2008; d_rd_size = 2'd2;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("d_rdy_blocked", d_rd_rdy, 0);
            check("unfinish_blocked", read_unfinish, 0);
            tick();
        end
        wr_idle = 1'b1;
        #1;
        check("d_rdy_release", d_rd_rdy, 1);
        push_ar(1, 0, 32'h0000_2008, 2'd2);
        tick();
        d_rd_req = 1'b0;
        ar_phase(0);
        beat(1, 1);

        // reset during beat 2 of an inst burst
        request(0, 1, 32'h0000_2000, 2'd0);
        ar_phase(0);
        beat(0, 0);
        reset = 1'b1;
        beat(0, 0);
        rvalid = 1'b1;
        #1;
        check_quiet("mid_reset");
        check("mid_reset_araddr", araddr, 0);
        check("mid_reset_arlen", arlen, 0);
        reset = 1'b0;
        rvalid = 1'b0;
        tick();
        request(0, 0, 32'h0000_3000, 2'd0);
        ar_phase(0);
        beat(0, 1);

        // conflict arbitration with both requesters held
        i_rd_req = 1'b1; i_rd_burst = 1'b0; i_rd_addr = 32'h0000_4000;
        d_rd_req = 1'b1; d_rd_burst = 1'b0; d_rd_addr = 32'h0000_5000; d_rd_size = 2'd2;
        for (int t = 0; t < 4; t++) begin
`ifdef RD_ARB_RR_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #1;
            check("arb_d_rdy", d_rd_rdy, exp_d);
            check("arb_i_rdy", i_rd_rdy, !exp_d);
            push_ar(exp_d, 0, exp_d ? 32'h0000_5000 : 32'h0000_4000, 2'd2);
            tick();
            ar_phase(0);
            beat(exp_d, 1);
        end
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        #1;
        check_quiet("end");
        check("ar_q_empty", ar_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
